// File: rtl/lf_ssp_serializer_if.sv
// Sample bus between the LF capture logic and the SSP serializer.
interface lf_ssp_serializer_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/lf_ssp_serializer.sv
// LF sample FIFO + MSB-first SSP shifter toward the ARM.
// Define LF_SSP_PARITY_EN to append an even-parity bit to every word.
module lf_ssp_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SSP_HALF   = 2,
    parameter int SAMPLE_W   = 8,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              pck0,
    input  logic              rst,
    input  logic              enable,
    lf_ssp_serializer_if.slave smp,
    output logic [LW-1:0]     fifo_level,
    output logic              overflow,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SSP_HALF > 1) ? $clog2(SSP_HALF) : 1;
`ifdef LF_SSP_PARITY_EN
    localparam int NBITS = SAMPLE_W + 1;
`else
    localparam int NBITS = SAMPLE_W;
`endif
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] HALF_TC = CW'(SSP_HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [SAMPLE_W-1:0] head;
    logic                full, empty, push, drop, pop, flush;
    logic                ssp_fall, last_bit;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_idx;
    logic [SAMPLE_W-2:0] sreg;
`ifdef LF_SSP_PARITY_EN
    logic                par;
`endif

    assign full   = (fifo_level == LW'(FIFO_DEPTH));
    assign empty  = (fifo_level == '0);
    assign head   = mem[rd_ptr];
    assign push   = smp.sample_valid & enable & ~full;
    assign drop   = smp.sample_valid & enable & full;
    assign smp.sample_ready = ~full;

    assign ssp_fall = (state == SHIFT) && (cnt == HALF_TC) && ssp_clk;
    assign last_bit = (bit_idx == LAST_BIT);
    // Pop either from idle or on the closing falling edge of a word.
    assign pop   = enable & ~empty &
                   ((state == IDLE) | (ssp_fall & last_bit));
    assign flush = ssp_fall & last_bit & ~enable;

    always_ff @(posedge pck0) begin
        if (push) mem[wr_ptr] <= smp.sample_data;
    end

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= wr_ptr;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            sreg      <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
`ifdef LF_SSP_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    ssp_clk   <= 1'b0;
                    ssp_frame <= 1'b0;
                    ssp_din   <= 1'b0;
                    if (pop) begin
                        state     <= SHIFT;
                        sreg      <= head[SAMPLE_W-2:0];
                        ssp_din   <= head[SAMPLE_W-1];
                        ssp_frame <= 1'b1;
                        bit_idx   <= '0;
                        cnt       <= '0;
`ifdef LF_SSP_PARITY_EN
                        par       <= ^head;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_TC) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt     <= '0;
                        ssp_clk <= ~ssp_clk;
                        if (ssp_clk && !last_bit) begin
                            sreg      <= sreg << 1;
                            ssp_frame <= 1'b0;
                            bit_idx   <= bit_idx + 1'b1;
`ifdef LF_SSP_PARITY_EN
                            ssp_din   <= (bit_idx == BW'(SAMPLE_W - 1)) ?
                                         par : sreg[SAMPLE_W-2];
`else
                            ssp_din   <= sreg[SAMPLE_W-2];
`endif
                        end else if (ssp_clk && pop) begin
                            // Back-to-back word: reload on the same edge.
                            ssp_clk   <= 1'b0;
                            sreg      <= head[SAMPLE_W-2:0];
                            ssp_din   <= head[SAMPLE_W-1];
                            ssp_frame <= 1'b1;
                            bit_idx   <= '0;
`ifdef LF_SSP_PARITY_EN
                            par       <= ^head;
`endif
                        end else if (ssp_clk) begin
                            state     <= IDLE;
                            ssp_clk   <= 1'b0;
                            ssp_frame <= 1'b0;
                            ssp_din   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/lf_ssp_serializer.md
Name: lf_ssp_serializer

Overview:
- Downstream stage of the LF ADC capture modes. Takes 8-bit samples from the LF reader/ADC path and buffers them in a small FIFO.
- Shifts each sample MSB-first to the ARM over the SSP pins (ssp_clk, ssp_frame, ssp_din), one frame pulse per word.
- Sits between the LF capture logic and the SSP output muxes. The producer never stalls; overflow is reported, not back-pressured.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries (power of two, >= 2).
- SSP_HALF, 2, pck0 cycles per ssp_clk half period (>= 1).
- SAMPLE_W, 8, sample width in bits.

Ports:
- pck0  input  1  sole clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  serializer/FIFO enable.
- sample_data  input  SAMPLE_W  sample from capture logic.
- sample_valid  input  1  one-cycle strobe, sample_data valid.
- sample_ready  output  1  FIFO not full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a sample was dropped.
- ssp_clk  output  1  serial clock to ARM.
- ssp_frame  output  1  high during the MSB bit period of each word.
- ssp_din  output  1  serial data to ARM.

Behaviour:
- Reset (async, immediate): FIFO empty, fifo_level=0, overflow=0, ssp_clk=0, ssp_frame=0, ssp_din=0, state IDLE, half counter 0. sample_ready=1 after reset.
- Write path:
  - sample_valid & enable & !full: write to the FIFO at this edge.
  - sample_valid & enable & full: sample dropped, overflow<=1. This holds even if a pop happens in the same cycle.
  - sample_valid & !enable: ignored, overflow unchanged.
  - sample_ready = !full, combinational from the pointers.
- Simultaneous push and pop with FIFO not full: both occur, level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE:
  - ssp_clk=0, ssp_frame=0, ssp_din=0.
  - If enable & FIFO non-empty: pop the head into the shift register, drive ssp_din=bit[SAMPLE_W-1], ssp_frame=1, bit index=0, half counter=0, go SHIFT.
  - Latency: a sample written at edge t is loaded at edge t+1 when the FSM is idle.
- FSM SHIFT:
  - The half counter counts 0..SSP_HALF-1. At terminal count it toggles ssp_clk and resets.
  - Falling edge of ssp_clk: shift left and present the next bit on ssp_din. Clear ssp_frame after the first bit. Increment the bit index.
  - ssp_din/ssp_frame change only coincident with ssp_clk falling (or on load); the ARM samples on ssp_clk rising.
  - One bit period is 2*SSP_HALF cycles.
- End of word, on the falling edge after the last bit:
  - If enable & FIFO non-empty: pop the next word on that same edge and continue back-to-back with no gap; frame rises again.
  - Else: go IDLE, outputs to 0.
- enable deasserted mid-word: the current word completes unchanged. On return to IDLE with enable=0, all FIFO entries are discarded (level=0) and overflow is cleared.
- overflow is cleared only by rst or by the flush above.

Optional Feature:
- LF_SSP_PARITY_EN defined: after the LSB, one extra bit period carries even parity over the word (XOR of all SAMPLE_W bits). Word length is SAMPLE_W+1 bit periods; frame timing is unchanged.
- LF_SSP_PARITY_EN undefined: word is exactly SAMPLE_W bit periods, with no parity logic.

Test Plan:
- Single sample, defaults: rst, enable=1, write 0xA5 at cycle 0 -> load at cycle 1; ssp_frame high cycles 1-4; ssp_clk rises at 3, 7, ...; ARM-side rising-edge sampling reads 1,0,1,0,0,1,0,1; IDLE at cycle 33, FIFO empty.
- Back-to-back: write 0x01,0x02,0x03 on consecutive cycles -> three contiguous 32-cycle words with no idle gap; ssp_frame pulses at cycles 1, 33, 65; fifo_level peaks at 2.
- Overflow: with one word shifting, write 5 samples in 5 cycles (FIFO_DEPTH=4) -> first 4 accepted, 5th dropped; sample_ready=0 at that cycle; overflow=1 and stays 1 while words drain.
- Disable mid-word: enable=0 at bit 3 of 0xF0 with 2 entries queued -> full 0xF0 shifted out, then level=0, overflow=0, no further frames.
- Async reset mid-word: assert rst at bit 5, between clock edges -> all outputs 0 immediately; after release, sample 0x3C shifts out correctly from cycle 1.
- Parity (LF_SSP_PARITY_EN): sample 0x07 -> 9 bit periods (36 cycles); 9th bit=1; sample 0x03 -> 9th bit=0.
